mem_wb_writeback: RTL

- MEM/WB pipeline register and writeback select for the 64-bit RV64I core.
- Captures MEM-stage results, sign/zero-extends load data and selects the writeback source.
- Drives register_file's write_reg / write_data / reg_write_en directly.
- Supports stall (hold) and flush (bubble insert).

---
 rtl/wb_pkg.sv | 29 ++
 rtl/mem_wb_writeback_load_extend.sv | 51 +++++
 rtl/mem_wb_writeback.sv | 117 +++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_pkg
// Description : Shared constants for the MEM/WB writeback stage: datapath
//               width, writeback source selects and load funct3 encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_pkg;

    localparam int XLEN       = 64;
    localparam int REG_ADDR_W = 5;

    // Writeback source select
    localparam logic [1:0] WB_SEL_ALU  = 2'b00;
    localparam logic [1:0] WB_SEL_MEM  = 2'b01;
    localparam logic [1:0] WB_SEL_PC4  = 2'b10;
    localparam logic [1:0] WB_SEL_RSVD = 2'b11;

    // Load funct3 encodings
    localparam logic [2:0] LOAD_LB  = 3'b000;
    localparam logic [2:0] LOAD_LH  = 3'b001;
    localparam logic [2:0] LOAD_LW  = 3'b010;
    localparam logic [2:0] LOAD_LD  = 3'b011;
    localparam logic [2:0] LOAD_LBU = 3'b100;
    localparam logic [2:0] LOAD_LHU = 3'b101;
    localparam logic [2:0] LOAD_LWU = 3'b110;

endpackage : wb_pkg
`default_nettype wire

// File: rtl/mem_wb_writeback_load_extend.sv
`default_nettype none
// ============================================================================
// Module      : load_extend
// Description : Combinational load alignment and sign/zero extension. The
//               doubleword read from memory is shifted right by the byte
//               offset (only the offset bits meaningful for the access size
//               are used) and then extended to 64 bits.
// Revision    : 1.0 - initial release
// ============================================================================
module load_extend
    import wb_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [2:0]      byte_off,
    input  logic [XLEN-1:0] mem_data,
    output logic [XLEN-1:0] ext_data
);

    logic [5:0]      shamt;
    logic [XLEN-1:0] shifted;

    // Aligned access: drop the low offset bits that fall inside the access size
    always_comb begin
        shamt = 6'd0;
        case (funct3[1:0])
            2'b00:   shamt = {byte_off, 3'b000};
            2'b01:   shamt = {byte_off[2:1], 4'b0000};
            2'b10:   shamt = {byte_off[2], 5'b00000};
            default: shamt = 6'd0;
        endcase
    end

    assign shifted = mem_data >> shamt;

    // Extend the selected lane according to load size and signedness
    always_comb begin
        ext_data = '0;
        case (funct3)
            LOAD_LB:  ext_data = {{56{shifted[7]}},  shifted[7:0]};
            LOAD_LH:  ext_data = {{48{shifted[15]}}, shifted[15:0]};
            LOAD_LW:  ext_data = {{32{shifted[31]}}, shifted[31:0]};
            LOAD_LD:  ext_data = shifted;
            LOAD_LBU: ext_data = {56'd0, shifted[7:0]};
            LOAD_LHU: ext_data = {48'd0, shifted[15:0]};
            LOAD_LWU: ext_data = {32'd0, shifted[31:0]};
            default:  ext_data = '0;
        endcase
    end

endmodule : load_extend
`default_nettype wire

// File: rtl/mem_wb_writeback.sv
`default_nettype none
// ============================================================================
// Module      : mem_wb_writeback
// Description : MEM/WB pipeline register with writeback source select. Holds
//               on stall, inserts a bubble on flush, and drives the register
//               file write port directly from stage registers.
//               Optional macro WB_INSTRET_EN adds a 64-bit retired
//               instruction counter output (instret).
// Revision    : 1.0 - initial release
// ============================================================================
module mem_wb_writeback
    import wb_pkg::*;
#(
    parameter int XLEN       = 64,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic                  in_reg_write,
    input  logic [1:0]            in_wb_sel,
    input  logic [2:0]            in_funct3,
    input  logic [2:0]            in_byte_off,
    input  logic [XLEN-1:0]       in_alu_result,
    input  logic [XLEN-1:0]       in_mem_data,
    input  logic [XLEN-1:0]       in_pc_plus4,
    output logic [REG_ADDR_W-1:0] write_reg,
    output logic [XLEN-1:0]       write_data,
    output logic                  reg_write_en,
`ifdef WB_INSTRET_EN
    output logic [63:0]           instret,
`endif
    output logic                  wb_valid
);

    logic                  valid_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic                  reg_write_q;
    logic [1:0]            wb_sel_q;
    logic [2:0]            funct3_q;
    logic [2:0]            byte_off_q;
    logic [XLEN-1:0]       alu_q;
    logic [XLEN-1:0]       mem_q;
    logic [XLEN-1:0]       pc4_q;
    logic [XLEN-1:0]       load_val;

    // Stage register: reset > flush > stall > capture
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q     <= 1'b0;
            rd_q        <= '0;
            reg_write_q <= 1'b0;
            wb_sel_q    <= 2'b00;
            funct3_q    <= 3'b000;
            byte_off_q  <= 3'b000;
            alu_q       <= '0;
            mem_q       <= '0;
            pc4_q       <= '0;
        end else if (flush) begin
            // Only the valid bit matters for a bubble; payload is left as is
            valid_q     <= 1'b0;
        end else if (!stall) begin
            valid_q     <= in_valid;
            rd_q        <= in_rd;
            reg_write_q <= in_reg_write;
            wb_sel_q    <= in_wb_sel;
            funct3_q    <= in_funct3;
            byte_off_q  <= in_byte_off;
            alu_q       <= in_alu_result;
            mem_q       <= in_mem_data;
            pc4_q       <= in_pc_plus4;
        end
    end

    load_extend u_load_extend (
        .funct3   (funct3_q),
        .byte_off (byte_off_q),
        .mem_data (mem_q),
        .ext_data (load_val)
    );

    // Writeback source select, driven from stage registers only
    always_comb begin
        write_data = '0;
        case (wb_sel_q)
            WB_SEL_ALU:  write_data = alu_q;
            WB_SEL_MEM:  write_data = load_val;
            WB_SEL_PC4:  write_data = pc4_q;
            WB_SEL_RSVD: write_data = '0;
            default:     write_data = '0;
        endcase
    end

    assign write_reg    = rd_q;
    assign wb_valid     = valid_q;
    assign reg_write_en = valid_q & reg_write_q & (rd_q != '0);

`ifdef WB_INSTRET_EN
    logic [63:0] instret_q;

    // Count the held instruction as it leaves the stage; flush does not block it
    always_ff @(posedge clk) begin
        if (reset) begin
            instret_q <= 64'd0;
        end else if (valid_q && !stall) begin
            instret_q <= instret_q + 64'd1;
        end
    end

    assign instret = instret_q;
`endif

endmodule : mem_wb_writeback
`default_nettype wire
